// File: rtl/load_ext_stage.sv
// Load-data extender: picks a byte/half/word/full lane from the memory word,
// zero- or sign-extends it, and registers the result behind a valid/ready stage.
module load_ext_stage #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [2:0]        in_mode,
  input  logic [4:0]        in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_tag,
  output logic              out_exc
);

  typedef enum logic [2:0] {
    MODE_FULL = 3'b000,
    MODE_BZ   = 3'b001,
    MODE_BS   = 3'b010,
    MODE_HZ   = 3'b011,
    MODE_HS   = 3'b100,
    MODE_WZ   = 3'b101,
    MODE_WS   = 3'b110,
    MODE_RSV  = 3'b111
  } mode_e;

  logic [OFF_W+2:0]  byte_idx;
  logic [OFF_W+2:0]  half_idx;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] word_zext;
  logic [DATA_W-1:0] word_sext;
  logic              word_ok;
  logic [DATA_W-1:0] ext_data;
  logic              ext_exc;
  logic              accept;

  assign byte_idx  = {in_off, 3'b000};
  assign half_idx  = {in_off[OFF_W-1:1], 4'b0000};
  assign byte_lane = in_data[byte_idx +: 8];
  assign half_lane = in_data[half_idx +: 16];

  // Word lanes only exist as a sub-lane on a 64-bit datapath.
  generate
    if (DATA_W == 64) begin : g_word64
      logic [OFF_W+2:0] word_idx;
      logic [31:0]      word_lane;
      assign word_idx  = {in_off[2], 5'b00000};
      assign word_lane = in_data[word_idx +: 32];
      assign word_zext = {{(DATA_W-32){1'b0}}, word_lane};
      assign word_sext = {{(DATA_W-32){word_lane[31]}}, word_lane};
      assign word_ok   = (in_off[1:0] == 2'b00);
    end else begin : g_word32
      assign word_zext = in_data;
      assign word_sext = in_data;
      assign word_ok   = 1'b0;
    end
  endgenerate

  always_comb begin
    ext_data = '0;
    ext_exc  = 1'b0;
    case (mode_e'(in_mode))
      MODE_FULL: begin
        ext_exc  = (in_off != '0);
        ext_data = in_data;
      end
      MODE_BZ: ext_data = {{(DATA_W-8){1'b0}}, byte_lane};
      MODE_BS: ext_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      MODE_HZ: begin
        ext_exc  = in_off[0];
        ext_data = {{(DATA_W-16){1'b0}}, half_lane};
      end
      MODE_HS: begin
        ext_exc  = in_off[0];
        ext_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
      end
      MODE_WZ: begin
        ext_exc  = !word_ok;
        ext_data = word_zext;
      end
      MODE_WS: begin
        ext_exc  = !word_ok;
        ext_data = word_sext;
      end
      default: ext_exc = 1'b1;
    endcase
    // A faulting entry must not leak memory data downstream.
    if (ext_exc) ext_data = '0;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_exc   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_exc   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= ext_data;
      out_tag   <= in_tag;
      out_exc   <= ext_exc;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_ext_stage.sv
// Directed bench for load_ext_stage: 32-bit instance for lane/handshake/flush/reset,
// 64-bit instance for word lanes.
module tb_load_ext_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0;
  logic [31:0] a_in_data = '0;
  logic [1:0]  a_in_off = '0;
  logic [2:0]  a_in_mode = '0;
  logic [4:0]  a_in_tag = '0;
  logic        a_out_valid, a_out_ready = 1'b1, a_out_exc;
  logic [31:0] a_out_data;
  logic [4:0]  a_out_tag;

  // 64-bit instance
  logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0;
  logic [63:0] b_in_data = '0;
  logic [2:0]  b_in_off = '0;
  logic [2:0]  b_in_mode = '0;
  logic [4:0]  b_in_tag = '0;
  logic        b_out_valid, b_out_ready = 1'b1, b_out_exc;
  logic [63:0] b_out_data;
  logic [4:0]  b_out_tag;

  load_ext_stage #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_off(a_in_off), .in_mode(a_in_mode), .in_tag(a_in_tag), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .out_exc(a_out_exc)
  );

  load_ext_stage #(.DATA_W(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_off(b_in_off), .in_mode(b_in_mode), .in_tag(b_in_tag), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_exc(b_out_exc)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] mode, input logic [1:0] off,
                         input logic [31:0] data, input logic [4:0] tag);
    a_in_valid = 1'b1;
    a_in_mode  = mode;
    a_in_off   = off;
    a_in_data  = data;
    a_in_tag   = tag;
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(a_out_valid), 64'd0);
    check("rst_data",  64'(a_out_data),  64'd0);
    check("rst_tag",   64'(a_out_tag),   64'd0);
    check("rst_exc",   64'(a_out_exc),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Byte lanes
    drive_a(3'b010, 2'd3, 32'h80FF_1234, 5'd5);
    step();
    check("bs_valid", 64'(a_out_valid), 64'd1);
    check("bs_data",  64'(a_out_data),  64'hFFFF_FF80);
    check("bs_exc",   64'(a_out_exc),   64'd0);
    check("bs_tag",   64'(a_out_tag),   64'd5);
    drive_a(3'b001, 2'd3, 32'h80FF_1234, 5'd6);
    step();
    check("bz_data",  64'(a_out_data),  64'h0000_0080);
    drive_a(3'b001, 2'd1, 32'h80FF_1234, 5'd6);
    step();
    check("bz1_data", 64'(a_out_data),  64'h0000_0012);

    // Half lanes and alignment faults
    drive_a(3'b100, 2'd2, 32'h9ABC_0001, 5'd7);
    step();
    check("hs_data", 64'(a_out_data), 64'hFFFF_9ABC);
    check("hs_exc",  64'(a_out_exc),  64'd0);
    drive_a(3'b011, 2'd2, 32'h9ABC_0001, 5'd7);
    step();
    check("hz_data", 64'(a_out_data), 64'h0000_9ABC);
    drive_a(3'b100, 2'd1, 32'h9ABC_0001, 5'd8);
    step();
    check("hmis_exc",  64'(a_out_exc),  64'd1);
    check("hmis_data", 64'(a_out_data), 64'd0);
    check("hmis_tag",  64'(a_out_tag),  64'd8);
    drive_a(3'b111, 2'd0, 32'h9ABC_0001, 5'd9);
    step();
    check("rsv_exc",  64'(a_out_exc),  64'd1);
    check("rsv_data", 64'(a_out_data), 64'd0);
    drive_a(3'b101, 2'd0, 32'h1234_5678, 5'd9);
    step();
    check("w32_exc",  64'(a_out_exc),  64'd1);
    drive_a(3'b000, 2'd2, 32'h1234_5678, 5'd9);
    step();
    check("fmis_exc", 64'(a_out_exc),  64'd1);

    // Back-to-back throughput
    for (int i = 1; i <= 4; i++) begin
      drive_a(3'b000, 2'd0, 32'h1111_1111 * i, 5'(i));
      #1;
      check($sformatf("b2b_ready%0d", i), 64'(a_in_ready), 64'd1);
      step();
      check($sformatf("b2b_valid%0d", i), 64'(a_out_valid), 64'd1);
      check($sformatf("b2b_tag%0d", i),   64'(a_out_tag),   64'(i));
      check($sformatf("b2b_data%0d", i),  64'(a_out_data),  64'(32'h1111_1111 * i));
    end
    a_in_valid = 1'b0;
    step();
    check("drain_valid", 64'(a_out_valid), 64'd0);
    check("drain_data",  64'(a_out_data),  64'h4444_4444);

    // Stall with a pending input, then release
    drive_a(3'b000, 2'd0, 32'hAAAA_5555, 5'd9);
    step();
    drive_a(3'b000, 2'd0, 32'h1234_5678, 5'd10);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 64'(a_in_ready), 64'd0);
      step();
      check($sformatf("stall_valid%0d", i), 64'(a_out_valid), 64'd1);
      check($sformatf("stall_tag%0d", i),   64'(a_out_tag),   64'd9);
      check($sformatf("stall_data%0d", i),  64'(a_out_data),  64'hAAAA_5555);
    end
    a_out_ready = 1'b1;
    #1;
    check("release_ready", 64'(a_in_ready), 64'd1);
    step();
    check("release_tag",  64'(a_out_tag),   64'd10);
    check("release_data", 64'(a_out_data),  64'h1234_5678);
    check("release_valid", 64'(a_out_valid), 64'd1);

    // Flush beats a simultaneous accept
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    step();
    drive_a(3'b000, 2'd0, 32'hDEAD_BEEF, 5'd11);
    a_out_ready = 1'b1;
    a_flush     = 1'b1;
    #1;
    check("flush_ready", 64'(a_in_ready), 64'd1);
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_tag",   64'(a_out_tag),   64'd10);
    check("flush_data",  64'(a_out_data),  64'h1234_5678);
    step();
    check("flush_idle", 64'(a_out_valid), 64'd0);

    // Exception cleared by flush
    drive_a(3'b111, 2'd0, 32'h0, 5'd3);
    step();
    a_in_valid = 1'b0;
    a_flush    = 1'b1;
    step();
    a_flush = 1'b0;
    check("flushexc_exc",   64'(a_out_exc),   64'd0);
    check("flushexc_valid", 64'(a_out_valid), 64'd0);

    // Asynchronous reset during a stall
    drive_a(3'b000, 2'd0, 32'h0000_0055, 5'd12);
    step();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    step();
    check("prerst_tag", 64'(a_out_tag), 64'd12);
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(a_out_valid), 64'd0);
    check("arst_data",  64'(a_out_data),  64'd0);
    check("arst_tag",   64'(a_out_tag),   64'd0);
    check("arst_exc",   64'(a_out_exc),   64'd0);
    step();
    @(negedge clk);
    reset_n     = 1'b1;
    a_out_ready = 1'b1;
    drive_a(3'b010, 2'd0, 32'h0000_007F, 5'd13);
    step();
    a_in_valid = 1'b0;
    check("postrst_valid", 64'(a_out_valid), 64'd1);
    check("postrst_data",  64'(a_out_data),  64'h0000_007F);
    check("postrst_tag",   64'(a_out_tag),   64'd13);

    // 64-bit word lanes
    b_in_valid = 1'b1; b_in_mode = 3'b110; b_in_off = 3'd4;
    b_in_data  = 64'h8000_0000_0000_0001; b_in_tag = 5'd20;
    step();
    check("w64s_data", b_out_data, 64'hFFFF_FFFF_8000_0000);
    check("w64s_exc",  64'(b_out_exc), 64'd0);
    check("w64s_tag",  64'(b_out_tag), 64'd20);
    b_in_mode = 3'b000; b_in_off = 3'd4; b_in_tag = 5'd21;
    step();
    check("f64mis_exc",  64'(b_out_exc), 64'd1);
    check("f64mis_data", b_out_data,     64'd0);
    b_in_mode = 3'b101; b_in_off = 3'd0; b_in_tag = 5'd22;
    step();
    check("w64z_data", b_out_data,     64'h0000_0000_0000_0001);
    check("w64z_exc",  64'(b_out_exc), 64'd0);
    b_in_mode = 3'b010; b_in_off = 3'd7; b_in_tag = 5'd23;
    step();
    check("b64s_data", b_out_data, 64'hFFFF_FFFF_FFFF_FF80);
    b_in_mode = 3'b100; b_in_off = 3'd6; b_in_data = 64'h1234_5678_9ABC_DEF0;
    step();
    check("h64s_data", b_out_data, 64'h0000_0000_0000_1234);
    b_in_mode = 3'b110; b_in_off = 3'd2;
    step();
    check("w64mis_exc", 64'(b_out_exc), 64'd1);
    b_in_valid = 1'b0;
    step();
    check("b_idle", 64'(b_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
